// File: rtl/muller_c_pkg.sv
// rtl/muller_c_pkg.sv - shared encodings, defaults and masked reduction helpers for muller_c_array
package muller_c_pkg;

    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_INPUTS      = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int MAX_INPUTS      = 8;

    // An empty mask never agrees, which is what disables a direction.
    function automatic logic masked_all_ones(input logic [MAX_INPUTS-1:0] val,
                                             input logic [MAX_INPUTS-1:0] mask);
        return (|mask) && ((val & mask) == mask);
    endfunction

    function automatic logic masked_all_zeros(input logic [MAX_INPUTS-1:0] val,
                                              input logic [MAX_INPUTS-1:0] mask);
        return (|mask) && ((val & mask) == '0);
    endfunction

endpackage

// File: rtl/muller_c_chan.sv
// rtl/muller_c_chan.sv - one generalised C-element channel with pulses, counter and hazard flag
module muller_c_chan
    import muller_c_pkg::*;
#(
    parameter int INPUTS = DEF_INPUTS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_init,
    input  logic [INPUTS-1:0] i_s,
    input  logic [INPUTS-1:0] i_plus,
    input  logic [INPUTS-1:0] i_minus,
    input  logic              i_clr,
    output logic              o_out,
    output logic              o_rise,
    output logic              o_fall,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_ovf,
    output logic              o_hazard
);

    logic [0:0]        r_state;
    logic [INPUTS-1:0] r_prev;
    logic              r_rise;
    logic              r_fall;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_hazard;

    logic w_rise_ok;
    logic w_fall_ok;
    logic w_go_high;
    logic w_go_low;
    logic w_event;
    logic w_withdraw;

    assign w_rise_ok = masked_all_ones(MAX_INPUTS'(i_s), MAX_INPUTS'(i_plus));
    assign w_fall_ok = masked_all_zeros(MAX_INPUTS'(i_s), MAX_INPUTS'(i_minus));
    assign w_go_high = i_en && (r_state == ST_LOW)  && w_rise_ok && !w_fall_ok;
    assign w_go_low  = i_en && (r_state == ST_HIGH) && w_fall_ok && !w_rise_ok;
    assign w_event   = w_go_high || w_go_low;

    // A participating input backing off before the channel fired.
    assign w_withdraw = i_en && ((r_state == ST_LOW) ? |(i_plus & r_prev & ~i_s)
                                                     : |(i_minus & ~r_prev & i_s));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= i_init;
            r_prev   <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_hazard <= 1'b0;
        end else begin
            r_prev <= i_s;
            r_rise <= w_go_high;
            r_fall <= w_go_low;
            if (w_go_high) begin
                r_state <= ST_HIGH;
            end else if (w_go_low) begin
                r_state <= ST_LOW;
            end
            if (i_clr) begin
                r_count <= w_event ? CNT_W'(1) : '0;
                r_ovf   <= 1'b0;
            end else if (w_event) begin
                r_count <= r_count + CNT_W'(1);
                if (&r_count) begin
                    r_ovf <= 1'b1;
                end
            end
            r_hazard <= (r_hazard && !i_clr) || w_withdraw;
        end
    end

    assign o_out    = r_state[0];
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_count  = r_count;
    assign o_ovf    = r_ovf;
    assign o_hazard = r_hazard;

endmodule

// File: rtl/muller_c_array.sv
// rtl/muller_c_array.sv - synchroniser bank feeding an array of Muller C-element channels
module muller_c_array
    import muller_c_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int INPUTS      = DEF_INPUTS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic [CHANNELS*INPUTS-1:0]   io_in,
    input  logic [CHANNELS*INPUTS-1:0]   plus_mask,
    input  logic [CHANNELS*INPUTS-1:0]   minus_mask,
    input  logic [CHANNELS-1:0]          init_val,
    input  logic                         clr,
    output logic [CHANNELS-1:0]          io_out,
    output logic [CHANNELS-1:0]          rise_p,
    output logic [CHANNELS-1:0]          fall_p,
    output logic [CHANNELS*CNT_W-1:0]    tcount,
    output logic [CHANNELS-1:0]          ovf,
    output logic [CHANNELS-1:0]          hazard
);

    localparam int W = CHANNELS * INPUTS;

    logic [W-1:0]             r_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0]   r_valid;
    logic [W-1:0]             w_s;
    logic                     w_en;

    // r_valid keeps channels idle until real samples have filled the chain after reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_valid <= '0;
        end else begin
            r_sync[0] <= io_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_valid <= (r_valid << 1) | SYNC_STAGES'(1);
        end
    end

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign w_en = r_valid[SYNC_STAGES-1];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        muller_c_chan #(
            .INPUTS (INPUTS),
            .CNT_W  (CNT_W)
        ) u_chan (
            .i_clk    (wb_clk_i),
            .i_rst    (wb_rst_i),
            .i_en     (w_en),
            .i_init   (init_val[c]),
            .i_s      (w_s[c*INPUTS +: INPUTS]),
            .i_plus   (plus_mask[c*INPUTS +: INPUTS]),
            .i_minus  (minus_mask[c*INPUTS +: INPUTS]),
            .i_clr    (clr),
            .o_out    (io_out[c]),
            .o_rise   (rise_p[c]),
            .o_fall   (fall_p[c]),
            .o_count  (tcount[c*CNT_W +: CNT_W]),
            .o_ovf    (ovf[c]),
            .o_hazard (hazard[c])
        );
    end

endmodule

// File: doc/muller_c_array.md
# muller_c_array

Parametrised, clocked emulation of an array of generalised Muller C-elements for the async project area. Each of CHANNELS channels combines INPUTS synchronised inputs under per-input plus/minus masks. Each channel holds its output until all participating inputs agree, then counts transitions and flags protocol hazards. It replaces the fixed single C-element test structure and sits behind the project's io_in pins with results on io_out.

## Interface
- CHANNELS, 2, number of independent C-element channels (1..8)
- INPUTS, 3, inputs per channel (2..8)
- SYNC_STAGES, 2, flop stages on every io_in bit (>=1)
- CNT_W, 8, width of each per-channel transition counter

- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous, active-high reset
- io_in  in  CHANNELS*INPUTS  raw async inputs; channel c owns bits [c*INPUTS +: INPUTS]
- plus_mask  in  CHANNELS*INPUTS  1 = input participates in the rising condition
- minus_mask  in  CHANNELS*INPUTS  1 = input participates in the falling condition
- init_val  in  CHANNELS  io_out value loaded while reset is asserted
- clr  in  1  synchronous clear of counters and sticky flags
- io_out  out  CHANNELS  C-element outputs
- rise_p  out  CHANNELS  one-cycle pulse on each 0->1 of io_out
- fall_p  out  CHANNELS  one-cycle pulse on each 1->0 of io_out
- tcount  out  CHANNELS*CNT_W  per-channel transition count
- ovf  out  CHANNELS  sticky: counter wrapped
- hazard  out  CHANNELS  sticky: a participating input withdrew before the output fired

## Operation
- Sync: each io_in bit passes through SYNC_STAGES flops. The result s is the only input view used below.
- Per channel, P = plus-masked inputs and M = minus-masked inputs.
  - rise_ok = P nonempty AND all P bits = 1.
  - fall_ok = M nonempty AND all M bits = 0.
- Channel state is the io_out bit:
  - LOW -> HIGH when rise_ok and not fall_ok.
  - HIGH -> LOW when fall_ok and not rise_ok.
  - Otherwise hold.
  - rise_ok and fall_ok together (disjoint masks) resolve to hold.
- An empty mask disables that transition direction. Masks are sampled every cycle with no registering. A mask change takes effect on the next edge.
- Transition event:
  - rise_p or fall_p is high for exactly one cycle.
  - tcount increments by 1 modulo 2^CNT_W.
  - On wrap from all-ones to 0, ovf sets.
- Hazard:
  - In LOW, a P input that was 1 in the previous cycle and is now 0, while rise_ok has not yet fired, sets hazard.
  - Symmetrically in HIGH for an M input going 0->1.
  - The previous-sample register updates every cycle.
- clr:
  - Zeroes tcount, ovf and hazard.
  - Does not touch io_out or the sync chain.
  - clr in the same cycle as an event: the count ends at 1 and the pulse still fires.
- Reset:
  - io_out = init_val, rise_p = fall_p = 0, tcount = 0, ovf = 0, hazard = 0.
  - Sync flops and previous-sample registers are loaded to 0.
  - Reset asserted mid-transition aborts it; no pulse is emitted.

## Timing
- io_in edge to io_out change: SYNC_STAGES+1 rising edges, so 3 at default.
- rise_p and fall_p are asserted in the same cycle io_out first shows the new value.
- tcount and ovf update in that same cycle.
- hazard sets one cycle after the withdrawing sample appears at the sync output.
- After reset release, the first possible io_out change is SYNC_STAGES+1 edges later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package muller_c_pkg holds:
  - state encodings ST_LOW = 1'b0, ST_HIGH = 1'b1;
  - default parameter values;
  - a reduction helper for masked all-ones and all-zeros tests.
- Sub-module muller_c_chan holds one channel: rise/fall logic, pulse, counter, hazard.
- The top instantiates the shared sync bank and generates CHANNELS copies of muller_c_chan.

## Test plan
- Basic rise, default params, full masks, init_val = 0:
  - Drive channel 0 inputs to 3'b111.
  - io_out[0] = 1 exactly 3 edges later, with a one-cycle rise_p[0] and tcount[0] = 1.
  - Drive back to 3'b000; fall_p[0] fires and tcount[0] = 2.
- Partial agreement: inputs 3'b011 held for 20 cycles -> io_out stays 0, no pulses, hazard stays 0.
- Asymmetric masks:
  - plus_mask = 3'b001, minus_mask = 3'b111.
  - Input 3'b001 -> rise.
  - Then 3'b000 -> fall.
  - Then 3'b101 -> rise again; tcount = 3.
- Hazard:
  - Inputs 3'b011, then 3'b001 before bit 2 arrives -> hazard[0] = 1 and io_out unchanged.
  - clr -> hazard[0] = 0.
- Wrap, CNT_W = 2: five transitions -> tcount = 1 and ovf = 1. clr in the same cycle as a sixth transition -> tcount = 1 and ovf = 0.
- Async reset with init_val = 2'b10, asserted mid-sync-chain:
  - io_out becomes 2'b10 immediately, without waiting for a clock edge, and no pulse is emitted.
  - After release, the pending input needs the full 3 edges to propagate.
